spi_slave: RTL and testbench

//  SPI mode-0 (CPOL=0, CPHA=0), MSB-first responder; counterpart of spi_master on the same SCK/CS/MOSI/MISO link.

---
 rtl/spi_slave.sv | 216 +++++++++++++++++++++
 tb/tb_spi_slave.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 (CPOL=0, CPHA=0), MSB-first responder.
// SCK, CS and MOSI are oversampled on clk through equal-depth synchronisers.
// Edges are detected on the synchronised copies. Received words appear on
// rx_data with a one-cycle rx_valid pulse. Transmit words enter a one-word
// buffer through a valid/ready handshake.
//
// Handshake: tx_data is captured on a rising clk edge where tx_valid and
// tx_ready are both 1. tx_ready is a registered "buffer empty" flag. It drops
// the cycle after a capture and rises again the cycle after the word is
// loaded into the shift register. While tx_ready is 0, tx_data/tx_valid are
// ignored and the offer must be held.
//
// clk must run at least 4x faster than SCK.

module spi_slave #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  SCK,
    input  logic                  CS,
    input  logic                  MOSI,
    output logic                  MISO,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  tx_underrun,
    output logic                  frame_err,
    output logic                  state_dbg
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    // Synchroniser chains; bit 0 samples the pin, the top bit is the synced value.
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;

    logic sck_s;
    logic cs_s;
    logic mosi_s;
    logic sck_prev;
    logic cs_prev;

    logic sck_rise;
    logic sck_fall;
    logic cs_rise;
    logic cs_fall;

    // Frame control decoded from the FSM.
    logic start_frame;
    logic end_frame;
    logic bit_rise;
    logic bit_fall;
    logic word_load;

    // Receive datapath.
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-2:0] rx_shift;
    logic [DATA_WIDTH-1:0] rx_word;

    // Transmit datapath.
    logic [DATA_WIDTH-1:0] tx_buf;
    logic                  tx_full;
    logic [DATA_WIDTH-1:0] tx_shift;

    // Pin synchronisers. CS resets to 0 ("selected"), so a frame that was
    // already running when reset hit is never mistaken for a new CS fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync  <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
        end
    end

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // Previous synced SCK/CS values, used for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_prev <= 1'b0;
            cs_prev  <= 1'b0;
        end else begin
            sck_prev <= sck_s;
            cs_prev  <= cs_s;
        end
    end

    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;
    assign cs_rise  = cs_s & ~cs_prev;
    assign cs_fall  = ~cs_s & cs_prev;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state. A frame starts on a CS fall and ends on a CS rise.
    always_comb begin
        state_d     = state_q;
        start_frame = 1'b0;
        end_frame   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d     = ACTIVE;
                    start_frame = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d   = IDLE;
                    end_frame = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // SCK edges count only inside a frame, and a CS rise in the same cycle
    // takes priority: the frame ends and the edge is dropped.
    assign bit_rise  = (state_q == ACTIVE) && !cs_rise && sck_rise;
    assign bit_fall  = (state_q == ACTIVE) && !cs_rise && sck_fall;
    // Word load happens at frame start and at each falling edge on a word
    // boundary, which sets up the next word of a back-to-back transfer.
    assign word_load = start_frame || (bit_fall && (bit_cnt == '0));

    assign rx_word = {rx_shift, mosi_s};

    // Receive shifter, bit counter, rx pulse and frame-error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= '0;
            rx_shift  <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (start_frame) begin
                bit_cnt <= '0;
            end else if (end_frame) begin
                bit_cnt   <= '0;
                frame_err <= (bit_cnt != '0);
            end else if (bit_rise) begin
                rx_shift <= rx_word[DATA_WIDTH-2:0];
                if (bit_cnt == LAST_BIT) begin
                    rx_data  <= rx_word;
                    rx_valid <= 1'b1;
                    bit_cnt  <= '0;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

    // Transmit buffer and shifter. A load from an empty buffer sends zeros
    // and flags an underrun. A capture can coincide with an underrun load,
    // because the buffer was empty and tx_ready was already high.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_buf      <= '0;
            tx_full     <= 1'b0;
            tx_shift    <= '0;
            tx_underrun <= 1'b0;
        end else begin
            tx_underrun <= 1'b0;
            if (word_load) begin
                tx_shift    <= tx_full ? tx_buf : '0;
                tx_underrun <= !tx_full;
                tx_full     <= 1'b0;
            end else if (end_frame) begin
                tx_shift <= '0;
            end else if (bit_fall) begin
                tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
            end
            if (tx_valid && !tx_full) begin
                tx_buf  <= tx_data;
                tx_full <= 1'b1;
            end
        end
    end

    assign MISO      = (state_q == ACTIVE) & tx_shift[DATA_WIDTH-1];
    assign tx_ready  = !tx_full;
    assign busy      = (state_q == ACTIVE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed scenarios for spi_slave at SCK = clk/8.
// The expected rx words and MISO words are queued when a frame is issued.
// Monitors pop the queues and compare as the DUT produces its outputs.

module tb_spi_slave;

  localparam int W    = 8;
  localparam int HALF = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         SCK = 1'b0;
  logic         CS = 1'b1;
  logic         MOSI = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         tx_valid = 1'b0;
  logic         MISO;
  logic         tx_ready;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         busy;
  logic         tx_underrun;
  logic         frame_err;
  logic         state_dbg;

  int n_checks = 0;
  int n_fail = 0;
  int rx_cnt = 0;
  int underrun_cnt = 0;
  int ferr_cnt = 0;
  int miso_bits = 0;
  bit mon_en = 1'b0;
  logic [W-1:0] miso_word = '0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] miso_exp_q[$];

  spi_slave #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .SCK(SCK), .CS(CS), .MOSI(MOSI), .MISO(MISO),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .tx_underrun(tx_underrun), .frame_err(frame_err), .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: rx words and pulse counters
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rx: got 0x%0h expected no word", rx_data);
      end else begin
        check("rx_data", {24'b0, rx_data}, {24'b0, exp_q.pop_front()});
      end
    end
    if (tx_underrun) underrun_cnt++;
    if (frame_err) ferr_cnt++;
  end

  // master-side MISO capture on SCK rise while selected
  always @(posedge SCK) begin
    if (mon_en && !CS) begin
      miso_word = {miso_word[W-2:0], MISO};
      miso_bits++;
      if (miso_bits == W) begin
        miso_bits = 0;
        if (miso_exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_miso: got 0x%0h expected no word", miso_word);
        end else begin
          check("miso_word", {24'b0, miso_word}, {24'b0, miso_exp_q.pop_front()});
        end
      end
    end
  end

  always @(posedge CS) miso_bits = 0;

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cs_fall();
    CS = 1'b0;
    tick(HALF);
  endtask

  // Sends the n MSBs of w. With end_frame set, CS rises together with the last SCK fall.
  task automatic send_bits(input logic [W-1:0] w, input int n, input bit end_frame);
    for (int i = 0; i < n; i++) begin
      MOSI = w[W-1-i];
      tick(HALF);
      SCK = 1'b1;
      tick(HALF);
      SCK = 1'b0;
      if (end_frame && i == n - 1) CS = 1'b1;
    end
  endtask

  task automatic tx_push(input logic [W-1:0] d);
    int t;
    t = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    while (!tx_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("tx_ready_for_push", {31'b0, tx_ready}, 32'd1);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string name);
    check(name, {25'b0, MISO, tx_ready, rx_valid, busy, tx_underrun, frame_err, state_dbg},
          32'b010_0000);
  endtask

  initial begin
    int rx0, ur0, fe0;

    // 1: reset with pins toggling
    for (int i = 0; i < 3; i++) begin
      SCK  = ~SCK;
      CS   = ~CS;
      MOSI = 1'($urandom_range(0, 1));
      tick(1);
      check_idle_outputs("reset_outputs");
      check("reset_rx_data", {24'b0, rx_data}, 32'h0);
    end
    SCK = 1'b0; CS = 1'b1; MOSI = 1'b0;
    rst = 1'b0;
    tick(6);
    check_idle_outputs("post_reset_outputs");
    check("post_reset_pulses", underrun_cnt + ferr_cnt + rx_cnt, 0);
    mon_en = 1'b1;
    miso_bits = 0;

    // 2: single frame, tx 0xA5, master sends 0xC9
    tx_push(8'hA5);
    check("tx_ready_full", {31'b0, tx_ready}, 32'd0);
    rx0 = rx_cnt; ur0 = underrun_cnt; fe0 = ferr_cnt;
    exp_q.push_back(8'hC9);
    miso_exp_q.push_back(8'hA5);
    cs_fall();
    check("busy_in_frame", {31'b0, busy}, 32'd1);
    check("tx_ready_after_cs_fall", {31'b0, tx_ready}, 32'd1);
    send_bits(8'hC9, 8, 1'b1);
    tick(8);
    check("single_rx_count", rx_cnt - rx0, 1);
    check("single_underrun", underrun_cnt - ur0, 0);
    check("single_frame_err", ferr_cnt - fe0, 0);
    check("single_rx_data_held", {24'b0, rx_data}, 32'hC9);
    check_idle_outputs("single_end_idle");

    // 3: back-to-back words in one frame
    tx_push(8'h5A);
    rx0 = rx_cnt; ur0 = underrun_cnt; fe0 = ferr_cnt;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'h81);
    miso_exp_q.push_back(8'h5A);
    miso_exp_q.push_back(8'h96);
    cs_fall();
    fork
      send_bits(8'h3C, 8, 1'b0);
      tx_push(8'h96);
    join
    check("b2b_busy_mid", {31'b0, busy}, 32'd1);
    send_bits(8'h81, 8, 1'b1);
    tick(8);
    check("b2b_rx_count", rx_cnt - rx0, 2);
    check("b2b_underrun", underrun_cnt - ur0, 0);
    check("b2b_frame_err", ferr_cnt - fe0, 0);

    // 4: underrun, master sends 0xFF with empty tx buffer
    rx0 = rx_cnt; ur0 = underrun_cnt;
    exp_q.push_back(8'hFF);
    miso_exp_q.push_back(8'h00);
    cs_fall();
    check("underrun_at_cs_fall", underrun_cnt - ur0, 1);
    send_bits(8'hFF, 8, 1'b1);
    tick(8);
    check("underrun_rx_count", rx_cnt - rx0, 1);
    check("underrun_rx_data", {24'b0, rx_data}, 32'hFF);

    // 5: abort after 5 bits, then a clean 0x12 frame
    rx0 = rx_cnt; fe0 = ferr_cnt;
    cs_fall();
    send_bits(8'hB7, 5, 1'b1);
    tick(8);
    check("abort_frame_err", ferr_cnt - fe0, 1);
    check("abort_rx_count", rx_cnt - rx0, 0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_rx_data_held", {24'b0, rx_data}, 32'hFF);
    rx0 = rx_cnt; fe0 = ferr_cnt;
    exp_q.push_back(8'h12);
    miso_exp_q.push_back(8'h00);
    cs_fall();
    send_bits(8'h12, 8, 1'b1);
    tick(8);
    check("after_abort_rx_count", rx_cnt - rx0, 1);
    check("after_abort_frame_err", ferr_cnt - fe0, 0);

    // 6: reset mid-frame with CS held low, then a fresh 0x7E frame
    rx0 = rx_cnt; fe0 = ferr_cnt;
    miso_exp_q.push_back(8'h00);
    cs_fall();
    send_bits(8'h7E, 3, 1'b0);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    check("midreset_busy", {31'b0, busy}, 32'd0);
    check("midreset_rx_data", {24'b0, rx_data}, 32'h0);
    send_bits(8'hF0, 5, 1'b1);
    tick(8);
    check("midreset_rx_count", rx_cnt - rx0, 0);
    check("midreset_frame_err", ferr_cnt - fe0, 0);
    tx_push(8'hE7);
    rx0 = rx_cnt; ur0 = underrun_cnt;
    exp_q.push_back(8'h7E);
    miso_exp_q.push_back(8'hE7);
    cs_fall();
    send_bits(8'h7E, 8, 1'b1);
    tick(8);
    check("post_reset_frame_rx_count", rx_cnt - rx0, 1);
    check("post_reset_frame_underrun", underrun_cnt - ur0, 0);

    // final report
    for (int i = 0; i < 100 && (exp_q.size() != 0 || miso_exp_q.size() != 0); i++) tick(1);
    check("rx_queue_drained", exp_q.size(), 0);
    check("miso_queue_drained", miso_exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
